// File: rtl/mem_access_stage_if.sv
// Bundles for the memory stage: E-stage request side, data-memory handshake
// and writeback outputs.

interface mas_ex_if;
    logic        validIn;
    logic [31:0] aluResultIn;
    logic [31:0] storeDataIn;
    logic        memReadIn;
    logic        memWriteIn;
    logic [1:0]  sizeIn;
    logic        signedLoadIn;
    logic        regWriteIn;
    logic [4:0]  writeRegIn;
    logic        stallOut;

    modport master (
        output validIn, aluResultIn, storeDataIn, memReadIn, memWriteIn,
               sizeIn, signedLoadIn, regWriteIn, writeRegIn,
        input  stallOut
    );
    modport slave (
        input  validIn, aluResultIn, storeDataIn, memReadIn, memWriteIn,
               sizeIn, signedLoadIn, regWriteIn, writeRegIn,
        output stallOut
    );
endinterface

interface mas_dmem_if;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemByteEn;
    logic [31:0] dmemWdata;
    logic        dmemAck;
    logic [31:0] dmemRdata;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemByteEn, dmemWdata,
        input  dmemAck, dmemRdata
    );
    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemByteEn, dmemWdata,
        output dmemAck, dmemRdata
    );
endinterface

interface mas_wb_if;
    logic        wbValid;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbData;
    logic        busErrOut;
    logic        misalignOut;

    modport master (
        output wbValid, wbRegWrite, wbWriteReg, wbData, busErrOut, misalignOut
    );
    modport slave (
        input  wbValid, wbRegWrite, wbWriteReg, wbData, busErrOut, misalignOut
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: req/ack data-memory access with lane steering, load
// extraction and timeout. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.

module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        resetN,
    mas_ex_if.slave     ex,
    mas_dmem_if.master  dmem,
    mas_wb_if.master    wb
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_stall;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [DATA_W-1:0]   r_dmem_addr;
    logic [3:0]          r_dmem_be;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic [1:0]          r_lo;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_is_store;
    logic                r_reg_write;
    logic [REG_W-1:0]    r_write_reg;
    logic                r_wb_valid;
    logic                r_wb_reg_write;
    logic [REG_W-1:0]    r_wb_write_reg;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_bus_err;

    logic                w_is_mem;
    logic [1:0]          w_a;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_ld_byte;
    logic [15:0]         w_ld_half;
    logic [DATA_W-1:0]   w_ld_data;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_timeout;

    assign w_is_mem   = ex.memReadIn | ex.memWriteIn;
    assign w_a        = ex.aluResultIn[1:0];
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_timeout  = (w_cnt_next == CNT_W'(MAX_WAIT));

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;
    logic w_misalign;
    assign w_misalign = ((ex.sizeIn == 2'b01) && w_a[0]) ||
                        (ex.sizeIn[1] && (w_a != 2'b00));
`endif

    // Little-endian lane steering for the incoming access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex.storeDataIn;
        case (ex.sizeIn)
            2'b00: begin
                w_be    = 4'(4'b0001 << w_a);
                w_wdata = {4{ex.storeDataIn[7:0]}};
            end
            2'b01: begin
                w_be    = w_a[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex.storeDataIn[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex.storeDataIn;
            end
        endcase
    end

    // Load data extraction from the latched lane and size
    always_comb begin
        w_ld_byte = 8'(dmem.dmemRdata >> {r_lo, 3'b000});
        w_ld_half = r_lo[1] ? dmem.dmemRdata[31:16] : dmem.dmemRdata[15:0];
        w_ld_data = dmem.dmemRdata;
        case (r_size)
            2'b00:   w_ld_data = r_signed ? {{24{w_ld_byte[7]}}, w_ld_byte}
                                          : {24'h000000, w_ld_byte};
            2'b01:   w_ld_data = r_signed ? {{16{w_ld_half[15]}}, w_ld_half}
                                          : {16'h0000, w_ld_half};
            default: w_ld_data = dmem.dmemRdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_stall        <= 1'b0;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_be      <= '0;
            r_dmem_wdata   <= '0;
            r_lo           <= '0;
            r_size         <= '0;
            r_signed       <= 1'b0;
            r_is_store     <= 1'b0;
            r_reg_write    <= 1'b0;
            r_write_reg    <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_write_reg <= '0;
            r_wb_data      <= '0;
            r_bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign     <= 1'b0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
            r_bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (ex.validIn) begin
                        if (!w_is_mem) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_data      <= ex.aluResultIn;
                            r_wb_reg_write <= ex.regWriteIn;
                            r_wb_write_reg <= ex.writeRegIn;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (w_misalign) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_reg_write <= 1'b0;
                            r_wb_write_reg <= ex.writeRegIn;
                            r_misalign     <= 1'b1;
                        end
`endif
                        else begin
                            r_state      <= S_WAIT;
                            r_cnt        <= '0;
                            r_stall      <= 1'b1;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= ex.memWriteIn;
                            r_dmem_addr  <= {ex.aluResultIn[31:2], 2'b00};
                            r_dmem_be    <= w_be;
                            r_dmem_wdata <= w_wdata;
                            r_lo         <= w_a;
                            r_size       <= ex.sizeIn;
                            r_signed     <= ex.signedLoadIn;
                            r_is_store   <= ex.memWriteIn;
                            r_reg_write  <= ex.regWriteIn;
                            r_write_reg  <= ex.writeRegIn;
                        end
                    end
                end
                S_WAIT: begin
                    // An ack on the final allowed cycle still completes normally
                    if (dmem.dmemAck) begin
                        r_state        <= S_IDLE;
                        r_stall        <= 1'b0;
                        r_dmem_req     <= 1'b0;
                        r_dmem_we      <= 1'b0;
                        r_dmem_be      <= '0;
                        r_wb_valid     <= 1'b1;
                        r_wb_write_reg <= r_write_reg;
                        r_wb_reg_write <= r_is_store ? 1'b0 : r_reg_write;
                        if (!r_is_store) begin
                            r_wb_data <= w_ld_data;
                        end
                    end else if (w_timeout) begin
                        r_state        <= S_IDLE;
                        r_cnt          <= w_cnt_next;
                        r_stall        <= 1'b0;
                        r_dmem_req     <= 1'b0;
                        r_dmem_we      <= 1'b0;
                        r_dmem_be      <= '0;
                        r_wb_valid     <= 1'b1;
                        r_wb_reg_write <= 1'b0;
                        r_wb_write_reg <= r_write_reg;
                        r_bus_err      <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ex.stallOut       = r_stall;
    assign dmem.dmemReq      = r_dmem_req;
    assign dmem.dmemWe       = r_dmem_we;
    assign dmem.dmemAddr     = r_dmem_addr;
    assign dmem.dmemByteEn   = r_dmem_be;
    assign dmem.dmemWdata    = r_dmem_wdata;
    assign wb.wbValid        = r_wb_valid;
    assign wb.wbRegWrite     = r_wb_reg_write;
    assign wb.wbWriteReg     = r_wb_write_reg;
    assign wb.wbData         = r_wb_data;
    assign wb.busErrOut      = r_bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    assign wb.misalignOut    = r_misalign;
`else
    assign wb.misalignOut    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized bench for mem_access_stage against an arithmetic
// reference model of lane steering, load extraction and timeout.

module tb_mem_access_stage;

    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic resetN;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mas_ex_if   ex_bus ();
    mas_dmem_if dm_bus ();
    mas_wb_if   wb_bus ();

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk    (clk),
        .resetN (resetN),
        .ex     (ex_bus),
        .dmem   (dm_bus),
        .wb     (wb_bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [1:0] sz);
        int unsigned a = 32'(addr[1:0]);
        if (sz == 2'b00)      return 4'(1 << a);
        else if (sz == 2'b01) return (a >= 2) ? 4'hC : 4'h3;
        else                  return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'b00)      return (d & 32'hFF) * 32'h0101_0101;
        else if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        else                  return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [31:0] rdata,
                                             input logic [1:0] sz, input logic sgn);
        int unsigned a = 32'(addr[1:0]);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rdata >> (8 * a)) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // One instruction from IDLE through completion; ack_at<0 withholds ack
    task automatic do_instr(input logic [31:0] alu, input logic [31:0] sd, input logic rd,
                            input logic wr, input logic [1:0] sz, input logic sgn,
                            input logic rw, input logic [4:0] wreg, input int ack_at,
                            input logic [31:0] rdata);
        logic is_mem;
        logic trap;
        bit   done;
        is_mem = rd | wr;
        trap   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = is_mem && (((sz == 2'b01) && alu[0]) || (sz[1] && (alu[1:0] != 2'b00)));
`endif
        ex_bus.validIn      = 1'b1;
        ex_bus.aluResultIn  = alu;
        ex_bus.storeDataIn  = sd;
        ex_bus.memReadIn    = rd;
        ex_bus.memWriteIn   = wr;
        ex_bus.sizeIn       = sz;
        ex_bus.signedLoadIn = sgn;
        ex_bus.regWriteIn   = rw;
        ex_bus.writeRegIn   = wreg;
        @(negedge clk);
        if (!is_mem) begin
            chk("alu_wb_valid", 32'(wb_bus.wbValid), 32'd1);
            chk("alu_wb_data", wb_bus.wbData, alu);
            chk("alu_wb_regwrite", 32'(wb_bus.wbRegWrite), 32'(rw));
            chk("alu_wb_writereg", 32'(wb_bus.wbWriteReg), 32'(wreg));
            chk("alu_stall", 32'(ex_bus.stallOut), 32'd0);
            chk("alu_req", 32'(dm_bus.dmemReq), 32'd0);
        end else if (trap) begin
            chk("mis_wb_valid", 32'(wb_bus.wbValid), 32'd1);
            chk("mis_flag", 32'(wb_bus.misalignOut), 32'd1);
            chk("mis_regwrite", 32'(wb_bus.wbRegWrite), 32'd0);
            chk("mis_req", 32'(dm_bus.dmemReq), 32'd0);
            chk("mis_stall", 32'(ex_bus.stallOut), 32'd0);
        end else begin
            chk("mem_req", 32'(dm_bus.dmemReq), 32'd1);
            chk("mem_stall", 32'(ex_bus.stallOut), 32'd1);
            chk("mem_we", 32'(dm_bus.dmemWe), 32'(wr));
            chk("mem_addr", dm_bus.dmemAddr, alu & 32'hFFFF_FFFC);
            chk("mem_be", 32'(dm_bus.dmemByteEn), 32'(exp_be(alu, sz)));
            if (wr) chk("mem_wdata", dm_bus.dmemWdata, exp_wdata(sd, sz));
            done = 1'b0;
            for (int k = 0; k < int'(MAX_WAIT) && !done; k++) begin
                ex_bus.aluResultIn = $urandom;
                ex_bus.storeDataIn = $urandom;
                ex_bus.sizeIn      = 2'($urandom_range(0, 3));
                dm_bus.dmemAck     = (k == ack_at);
                dm_bus.dmemRdata   = (k == ack_at) ? rdata : $urandom;
                @(negedge clk);
                dm_bus.dmemAck = 1'b0;
                if (k == ack_at) begin
                    chk("ack_wb_valid", 32'(wb_bus.wbValid), 32'd1);
                    chk("ack_regwrite", 32'(wb_bus.wbRegWrite), wr ? 32'd0 : 32'(rw));
                    chk("ack_writereg", 32'(wb_bus.wbWriteReg), 32'(wreg));
                    if (!wr) chk("ack_load_data", wb_bus.wbData, exp_load(alu, rdata, sz, sgn));
                    chk("ack_req_drop", 32'(dm_bus.dmemReq), 32'd0);
                    chk("ack_stall_drop", 32'(ex_bus.stallOut), 32'd0);
                    chk("ack_no_buserr", 32'(wb_bus.busErrOut), 32'd0);
                    done = 1'b1;
                end else if (k == int'(MAX_WAIT) - 1) begin
                    chk("to_buserr", 32'(wb_bus.busErrOut), 32'd1);
                    chk("to_wb_valid", 32'(wb_bus.wbValid), 32'd1);
                    chk("to_regwrite", 32'(wb_bus.wbRegWrite), 32'd0);
                    chk("to_req_drop", 32'(dm_bus.dmemReq), 32'd0);
                    chk("to_stall_drop", 32'(ex_bus.stallOut), 32'd0);
                    done = 1'b1;
                end else begin
                    chk("wait_req", 32'(dm_bus.dmemReq), 32'd1);
                    chk("wait_stall", 32'(ex_bus.stallOut), 32'd1);
                    chk("wait_wb_valid", 32'(wb_bus.wbValid), 32'd0);
                    chk("wait_addr", dm_bus.dmemAddr, alu & 32'hFFFF_FFFC);
                    chk("wait_be", 32'(dm_bus.dmemByteEn), 32'(exp_be(alu, sz)));
                end
            end
        end
        ex_bus.validIn = 1'b0;
        @(negedge clk);
        chk("pulse_wb_valid", 32'(wb_bus.wbValid), 32'd0);
        chk("pulse_buserr", 32'(wb_bus.busErrOut), 32'd0);
        chk("pulse_misalign", 32'(wb_bus.misalignOut), 32'd0);
        chk("idle_stall", 32'(ex_bus.stallOut), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(dm_bus.dmemReq), 32'd0);
        chk({tag, "_we"}, 32'(dm_bus.dmemWe), 32'd0);
        chk({tag, "_be"}, 32'(dm_bus.dmemByteEn), 32'd0);
        chk({tag, "_addr"}, dm_bus.dmemAddr, 32'd0);
        chk({tag, "_wdata"}, dm_bus.dmemWdata, 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_bus.wbValid), 32'd0);
        chk({tag, "_regwrite"}, 32'(wb_bus.wbRegWrite), 32'd0);
        chk({tag, "_writereg"}, 32'(wb_bus.wbWriteReg), 32'd0);
        chk({tag, "_wb_data"}, wb_bus.wbData, 32'd0);
        chk({tag, "_buserr"}, 32'(wb_bus.busErrOut), 32'd0);
        chk({tag, "_misalign"}, 32'(wb_bus.misalignOut), 32'd0);
        chk({tag, "_stall"}, 32'(ex_bus.stallOut), 32'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic        wr;
        logic        rd;
        int          ack_at;

        resetN              = 1'b0;
        ex_bus.validIn      = 1'b0;
        ex_bus.aluResultIn  = '0;
        ex_bus.storeDataIn  = '0;
        ex_bus.memReadIn    = 1'b0;
        ex_bus.memWriteIn   = 1'b0;
        ex_bus.sizeIn       = '0;
        ex_bus.signedLoadIn = 1'b0;
        ex_bus.regWriteIn   = 1'b0;
        ex_bus.writeRegIn   = '0;
        dm_bus.dmemAck      = 1'b0;
        dm_bus.dmemRdata    = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        resetN = 1'b1;
        @(negedge clk);

        // ADD with no memory op
        do_instr(32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3, 0, 32'h0);
        // Signed LB at 0x103, ack in the third WAIT cycle
        do_instr(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd7, 2, 32'h80FF_FFFF);
        // SH at 0x202, immediate ack
        do_instr(32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 5'd9, 0, 32'h0);
        // LW with ack withheld: timeout
        do_instr(32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd4, -1, 32'h0);
        // Ack on the last allowed cycle beats the timeout
        do_instr(32'h0000_0044, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd5, int'(MAX_WAIT) - 1,
                 32'hDEAD_BEEF);
        // LW at 0x06 (trapped or aligned down depending on build)
        do_instr(32'h0000_0006, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd6, 1, 32'h1234_5678);
        // Unsigned LH upper half
        do_instr(32'h0000_0012, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd8, 0, 32'h8765_4321);

        // Reset asserted in the second WAIT cycle abandons the access
        ex_bus.validIn      = 1'b1;
        ex_bus.aluResultIn  = 32'h0000_0080;
        ex_bus.memReadIn    = 1'b1;
        ex_bus.memWriteIn   = 1'b0;
        ex_bus.sizeIn       = 2'b10;
        ex_bus.regWriteIn   = 1'b1;
        ex_bus.writeRegIn   = 5'd11;
        @(negedge clk);
        chk("rst_wait_req", 32'(dm_bus.dmemReq), 32'd1);
        ex_bus.validIn = 1'b0;
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_wait");
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_after_wb_valid", 32'(wb_bus.wbValid), 32'd0);
        do_instr(32'h0000_0084, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd12, 0, 32'hCAFE_F00D);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            int op;
            op     = $urandom_range(0, 2);
            sz     = 2'($urandom_range(0, 3));
            ack_at = $urandom_range(0, 4);
            if (ack_at == 4) ack_at = -1;
            rd = 1'b0;
            wr = 1'b0;
            if (op == 1) rd = 1'b1;
            if (op == 2) begin
                wr = 1'b1;
                rd = 1'($urandom_range(0, 1));
            end
            do_instr($urandom, $urandom, rd, wr, sz, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ack_at, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage pipeline, directly downstream of the E-stage ALU. Takes the ALU result as the effective address (or passes it through as the writeback value), runs a req/ack handshake with data memory for loads and stores, and aligns, sign-extends and zero-extends load data. It drives the writeback-stage inputs and stalls the E stage while a memory access is outstanding.

## Interface
- MAX_WAIT, 255: cycles in WAIT without `dmemAck` before the access is aborted (1..255).
- clk  in  1  pipeline clock, rising edge.
- resetN  in  1  synchronous, active-low reset.
- validIn  in  1  E stage presents a valid instruction.
- aluResultIn  in  32  ALU result: byte address for memory ops, writeback data otherwise.
- storeDataIn  in  32  rt value to store.
- memReadIn / memWriteIn  in  1 each  load / store; both high is treated as store.
- sizeIn  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- signedLoadIn  in  1  sign-extend byte/half loads.
- regWriteIn  in  1  instruction writes a register.
- writeRegIn  in  5  destination register.
- stallOut  out  1  hold E stage.
- dmemReq  out  1  memory request.
- dmemWe  out  1  write enable.
- dmemAddr  out  32  word address ({addr[31:2],2'b00}).
- dmemByteEn  out  4  byte lanes.
- dmemWdata  out  32  lane-replicated store data.
- dmemAck  in  1  request completes this cycle.
- dmemRdata  in  32  read word, valid with `dmemAck`.
- wbValid  out  1  writeback entry valid (1-cycle pulse per instruction).
- wbRegWrite  out  1  writeback enable.
- wbWriteReg  out  5  destination register.
- wbData  out  32  result or load data.
- busErrOut  out  1  timeout pulse.
- misalignOut  out  1  misalignment pulse (tied to 0 without the macro).

## Operation
- FSM states: IDLE and WAIT. The state is IDLE out of reset.
- IDLE, validIn=1, no memory op: on the next edge, wbValid=1, wbData=aluResultIn, and wbRegWrite/wbWriteReg are taken from the inputs.
- IDLE, validIn=1, memory op: latch address, size, sign, store data, regWrite and writeReg, then move to WAIT. The beat counter clears.
- WAIT: dmemReq=1. Address, byte enables, wdata and We come from the latched values and stay stable until ack. stallOut=1, and validIn is ignored.
- WAIT with dmemAck=1: move to IDLE. On the same edge, wbValid=1.
  - Loads: wbData is the extracted load data, wbRegWrite is the latched regWrite.
  - Stores: wbRegWrite=0.
- WAIT without ack: the counter increments. When the counter equals MAX_WAIT: move to IDLE, drop dmemReq, and set busErrOut=1, wbValid=1, wbRegWrite=0 for one cycle.
- Lanes are little-endian; a = addr[1:0].
  - Byte: byteEn = 1<<a, wdata = {4{b}}.
  - Half: byteEn = a[1] ? 1100 : 0011, wdata = {2{h}}.
  - Word: byteEn = 1111.
- Load extraction uses the same lanes. Byte and half results are sign- or zero-extended to 32 per signedLoadIn.
- Simultaneous ack and timeout on the same cycle: ack wins.
- stallOut = (state==WAIT). It is registered-state derived, with no combinational path from validIn.

## Timing
- Reset (resetN=0 at an edge): state IDLE; dmemReq, dmemWe, dmemByteEn, dmemAddr, dmemWdata, wbValid, wbRegWrite, wbWriteReg, wbData, busErrOut, misalignOut and the counter all go to 0.
- Reset during WAIT: the access is abandoned, dmemReq drops after the edge, and no wbValid is produced.
- Non-memory latency: 1 cycle.
- Memory latency: accept edge, then at least one WAIT cycle, then wbValid the cycle after ack. With zero-wait memory this is 2 cycles.
- The E stage may present a new instruction in the first IDLE cycle after ack.
- wbValid, busErrOut and misalignOut are single-cycle pulses.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: a half access with a[0]=1, or a word access with a≠0, issues no request. On the next edge, wbValid=1, wbRegWrite=0 and misalignOut=1, and the FSM stays IDLE.
- MEM_MISALIGN_TRAP_EN undefined: the unused low address bits are ignored. Half accesses use a[1]; word accesses ignore a. misalignOut is constant 0.

## Test plan
- ADD result 0x0000_1234, no memory op -> next cycle wbValid=1, wbData=0x0000_1234, stallOut never high.
- Signed LB at 0x103, memory returns 0x80FF_FFFF with ack after 3 cycles -> dmemAddr=0x100, byteEn=1000, stallOut high for 3 cycles, wbData=0xFFFF_FF80.
- SH at 0x202, data 0x0000_ABCD, immediate ack -> byteEn=1100, wdata=0xABCD_ABCD, dmemWe=1, wbRegWrite=0.
- LW with ack withheld and MAX_WAIT=4 -> dmemReq high for 4 cycles, then busErrOut=1 and wbValid=1, wbRegWrite=0, FSM back to IDLE.
- LW at 0x06: with MEM_MISALIGN_TRAP_EN, misalignOut=1 and dmemReq never asserted; without it, dmemAddr=0x04 and byteEn=1111.
- Assert resetN=0 in the second WAIT cycle -> dmemReq=0 and all outputs 0 after the edge, no wbValid; the next instruction is accepted once reset is released.
